// File: rtl/mileage_disp_pkg.sv
// Shared types, segment encodings and helpers for the mileage display.
// Build option: LEADING_ZERO_BLANK_EN enables leading-zero blanking.
package mileage_disp_pkg;

   localparam int SEG_W = 8;

   // Segment order {a,b,c,d,e,f,g,dp}, active-high
   localparam logic [SEG_W-1:0] SEG_0     = 8'b1111_1100;
   localparam logic [SEG_W-1:0] SEG_1     = 8'b0110_0000;
   localparam logic [SEG_W-1:0] SEG_2     = 8'b1101_1010;
   localparam logic [SEG_W-1:0] SEG_3     = 8'b1111_0010;
   localparam logic [SEG_W-1:0] SEG_4     = 8'b0110_0110;
   localparam logic [SEG_W-1:0] SEG_5     = 8'b1011_0110;
   localparam logic [SEG_W-1:0] SEG_6     = 8'b1011_1110;
   localparam logic [SEG_W-1:0] SEG_7     = 8'b1110_0000;
   localparam logic [SEG_W-1:0] SEG_8     = 8'b1111_1110;
   localparam logic [SEG_W-1:0] SEG_9     = 8'b1111_0110;
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'b0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_t;

   function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // ceil(w / 3.32): decimal digits needed for a w-bit binary value
   function automatic int bcd_nibbles(input int w);
      return (w * 100 + 331) / 332;
   endfunction

endpackage

// File: rtl/mileage_display_scan_bin2bcd.sv
// Sequential double-dabble binary to BCD converter.
// One shift per cycle; done pulses in the cycle the result is final.
module bin2bcd_seq
   import mileage_disp_pkg::*;
#(
   parameter int BIN_W = 27,
   parameter int NIB   = bcd_nibbles(BIN_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [NIB*4-1:0] bcd
);

   localparam int CW = $clog2(BIN_W + 1);

   conv_state_t      state;
   logic [BIN_W-1:0] bin;
   logic [CW-1:0]    cnt;
   logic [NIB*4-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < NIB; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bin   <= '0;
         cnt   <= '0;
         bcd   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bin   <= din;
                  bcd   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd, bin} <= {adj, bin} << 1;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(BIN_W - 1)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mileage_display_scan.sv
// Mileage display: BCD conversion, multiplexed 7-seg scan, flowing LED bar.
// Build option: LEADING_ZERO_BLANK_EN blanks digits above the top nonzero one.
module mileage_display_scan
   import mileage_disp_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int BIN_W    = 27,
   parameter int LED_N    = 8,
   parameter int SCAN_DIV = 100000,
   parameter int FLOW_DIV = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              power_now,
   input  logic              dir,
   input  logic [BIN_W-1:0]  record,
   output logic [LED_N-1:0]  led,
   output logic [SEG_W-1:0]  seg_out,
   output logic [DIGITS-1:0] seg_an,
   output logic              overflow
);

   localparam int NIB = bcd_nibbles(BIN_W);
   localparam int EXT = (NIB > DIGITS) ? NIB : DIGITS;
   localparam int EW  = EXT * 4;
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW  = (FLOW_DIV > 1) ? $clog2(FLOW_DIV) : 1;

   logic [BIN_W-1:0]    last;
   logic                start;
   logic                busy;
   logic                done;
   logic [NIB*4-1:0]    bcd;
   logic [EW-1:0]       bcd_ext;

   logic [DIGITS*4-1:0] disp, new_disp, nxt_disp;
   logic [DIGITS-1:0]   blank, new_blank, nxt_blank;
   logic                ovf, new_ovf, nxt_ovf;

   logic [SW-1:0]       sdiv, sdiv_nxt;
   logic [FW-1:0]       fdiv, fdiv_nxt;
   logic [IW-1:0]       idx, idx_nxt;
   logic [LED_N-1:0]    pat, pat_nxt;
   logic                sdiv_wrap, fdiv_wrap;
   logic                pwr_q;
   logic [3:0]          dig;
   logic [SEG_W-1:0]    seg_nxt;

   assign start = ~busy & (record != last);

   bin2bcd_seq #(
      .BIN_W (BIN_W)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (record),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic seen;
`endif

   // Saturate to all nines when the value needs more than DIGITS digits
   always_comb begin
      bcd_ext  = EW'(bcd);
      new_ovf  = 1'b0;
      new_disp = '0;
      for (int i = DIGITS; i < EXT; i++)
         new_ovf = new_ovf | (bcd_ext[i*4 +: 4] != 4'd0);
      for (int i = 0; i < DIGITS; i++)
         new_disp[i*4 +: 4] = new_ovf ? 4'd9 : bcd_ext[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      seen      = 1'b0;
      new_blank = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         seen         = seen | (new_disp[i*4 +: 4] != 4'd0);
         new_blank[i] = ~seen;
      end
`else
      new_blank = '0;
`endif
   end

   always_comb begin
      nxt_disp  = done ? new_disp  : disp;
      nxt_blank = done ? new_blank : blank;
      nxt_ovf   = done ? new_ovf   : ovf;
   end

   always_comb begin
      sdiv_wrap = (sdiv == SW'(SCAN_DIV - 1));
      sdiv_nxt  = sdiv_wrap ? '0 : sdiv + 1'b1;
      fdiv_wrap = (fdiv == FW'(FLOW_DIV - 1));
      fdiv_nxt  = fdiv_wrap ? '0 : fdiv + 1'b1;
      if (!pwr_q)
         idx_nxt = '0;
      else if (sdiv_wrap)
         idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      else
         idx_nxt = idx;
      if (!fdiv_wrap)
         pat_nxt = pat;
      else if (dir)
         pat_nxt = {pat[0], pat[LED_N-1:1]};
      else
         pat_nxt = {pat[LED_N-2:0], pat[LED_N-1]};
   end

   // Encode from the next-cycle digits so a fresh result shows immediately
   always_comb begin
      dig     = nxt_disp[idx_nxt*4 +: 4];
      seg_nxt = nxt_blank[idx_nxt] ? SEG_BLANK : seg_encode(dig);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last     <= '0;
         disp     <= '0;
         blank    <= '0;
         ovf      <= 1'b0;
         sdiv     <= '0;
         fdiv     <= '0;
         idx      <= '0;
         pat      <= LED_N'(1);
         pwr_q    <= 1'b0;
         led      <= '0;
         seg_an   <= '0;
         seg_out  <= '0;
         overflow <= 1'b0;
      end else begin
         if (start)
            last <= record;
         disp  <= nxt_disp;
         blank <= nxt_blank;
         ovf   <= nxt_ovf;
         pwr_q <= power_now;
         if (power_now) begin
            sdiv     <= sdiv_nxt;
            fdiv     <= fdiv_nxt;
            idx      <= idx_nxt;
            pat      <= pat_nxt;
            led      <= pat_nxt;
            seg_an   <= DIGITS'(1) << idx_nxt;
            seg_out  <= seg_nxt;
            overflow <= nxt_ovf;
         end else begin
            pat      <= LED_N'(1);
            led      <= '0;
            seg_an   <= '0;
            seg_out  <= '0;
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mileage_display_scan.sv
// Self-checking bench for mileage_display_scan against a decimal-arithmetic model.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_mileage_display_scan;

   localparam int DIGITS   = 8;
   localparam int BIN_W    = 27;
   localparam int LED_N    = 8;
   localparam int SCAN_DIV = 4;
   localparam int FLOW_DIV = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             power_now = 1'b1;
   logic             dir = 1'b0;
   logic [BIN_W-1:0] record = '0;
   logic [LED_N-1:0] led;
   logic [7:0]       seg_out;
   logic [DIGITS-1:0] seg_an;
   logic             overflow;

   int total = 0;
   int bad   = 0;

   mileage_display_scan #(
      .DIGITS   (DIGITS),
      .BIN_W    (BIN_W),
      .LED_N    (LED_N),
      .SCAN_DIV (SCAN_DIV),
      .FLOW_DIV (FLOW_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .power_now (power_now),
      .dir       (dir),
      .record    (record),
      .led       (led),
      .seg_out   (seg_out),
      .seg_an    (seg_an),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   logic [7:0] tb_seg [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                               8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
      end
   endtask

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p;
   endfunction

   // Model: value shown, when a conversion lands, scan and LED positions
   bit         started = 0;
   int         m_left;
   longint     m_last, m_pend, m_val;
   int         m_sdiv, m_idx, m_fdiv, m_pat;
   bit         m_pwr_q;
   logic [7:0] e_led, e_seg, e_an;
   logic       e_ovf;

   always @(posedge clk) begin
      int d;
      bit ov, blk;
      started = 1;
      if (rst) begin
         m_left = 0; m_last = 0; m_pend = 0; m_val = 0;
         m_sdiv = 0; m_idx = 0; m_fdiv = 0; m_pat = 1; m_pwr_q = 0;
         e_led = 0; e_seg = 0; e_an = 0; e_ovf = 0;
      end else begin
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_val = m_pend;
         end else if (longint'(record) != m_last) begin
            m_last = longint'(record);
            m_pend = m_last;
            m_left = BIN_W + 1;
         end
         if (power_now) begin
            m_sdiv = (m_sdiv + 1) % SCAN_DIV;
            if (!m_pwr_q) m_idx = 0;
            else if (m_sdiv == 0) m_idx = (m_idx + 1) % DIGITS;
            m_fdiv = (m_fdiv + 1) % FLOW_DIV;
            if (m_fdiv == 0) begin
               if (dir) m_pat = (m_pat == 1) ? 128 : m_pat / 2;
               else     m_pat = (m_pat == 128) ? 1 : m_pat * 2;
            end
            ov  = m_val > pow10(DIGITS) - 1;
            d   = ov ? 9 : int'((m_val / pow10(m_idx)) % 10);
            blk = 0;
`ifdef LEADING_ZERO_BLANK_EN
            blk = !ov && m_idx > 0 && m_val < pow10(m_idx);
`endif
            e_led = 8'(m_pat);
            e_an  = 8'(1 << m_idx);
            e_seg = blk ? 8'h00 : tb_seg[d];
            e_ovf = ov;
         end else begin
            m_pat = 1;
            e_led = 0; e_seg = 0; e_an = 0; e_ovf = 0;
         end
         m_pwr_q = power_now;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("led", 32'(led), 32'(e_led));
         chk("seg_an", 32'(seg_an), 32'(e_an));
         chk("seg_out", 32'(seg_out), 32'(e_seg));
         chk("overflow", 32'(overflow), 32'(e_ovf));
      end
   end

   task automatic check_digit(input string name, input logic [7:0] an,
                              input logic [7:0] exp);
      int n = 0;
      while (seg_an !== an && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (seg_an !== an) begin
         total++;
         bad++;
         $display("FAIL %s anode got=%h want=%h", name, seg_an, an);
      end else begin
         chk(name, 32'(seg_out), 32'(exp));
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_led", 32'(led), 32'h01);
      chk("rst_an", 32'(seg_an), 32'h01);
      chk("rst_seg0", 32'(seg_out), 32'hFC);
      repeat (3) @(negedge clk);
      chk("an_step", 32'(seg_an), 32'h02);
      repeat (4) @(negedge clk);
      chk("led_step", 32'(led), 32'h02);

      record = 27'd12345678;
      repeat (29) @(negedge clk);
      check_digit("d0_8", 8'h01, 8'hFE);
      check_digit("d7_1", 8'h80, 8'h60);
      chk("ovf_12345678", 32'(overflow), 32'h0);

      record = 27'd99999999;
      repeat (30) @(negedge clk);
      check_digit("d0_9", 8'h01, 8'hF6);
      chk("ovf_9s", 32'(overflow), 32'h0);
      record = 27'd100000000;
      repeat (30) @(negedge clk);
      chk("ovf_sat", 32'(overflow), 32'h1);
      check_digit("d4_sat", 8'h10, 8'hF6);

      record = 27'd55;
      repeat (5) @(negedge clk);
      record = 27'd777;
      repeat (80) @(negedge clk);
      check_digit("d0_7", 8'h01, 8'hE0);
      check_digit("d2_7", 8'h04, 8'hE0);

      power_now = 1'b0;
      @(negedge clk);
      chk("off_led", 32'(led), 32'h0);
      chk("off_an", 32'(seg_an), 32'h0);
      chk("off_seg", 32'(seg_out), 32'h0);
      power_now = 1'b1;
      dir = 1'b1;
      @(negedge clk);
      chk("on_an", 32'(seg_an), 32'h01);
      n = 0;
      while (led == 8'h01 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("led_wrap_r", 32'(led), 32'h80);

      power_now = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_off_led", 32'(led), 32'h0);
      chk("rst_off_an", 32'(seg_an), 32'h0);
      chk("rst_off_ovf", 32'(overflow), 32'h0);
      rst = 1'b0;
      power_now = 1'b1;
      dir = 1'b0;
      repeat (40) @(negedge clk);
      check_digit("reconv_d1", 8'h02, 8'hE0);

      record = 27'd42;
      repeat (35) @(negedge clk);
      check_digit("d0_2", 8'h01, 8'hDA);
      check_digit("d1_4", 8'h02, 8'h66);
`ifdef LEADING_ZERO_BLANK_EN
      check_digit("d2_blank", 8'h04, 8'h00);
      check_digit("d7_blank", 8'h80, 8'h00);
      record = 27'd0;
      repeat (35) @(negedge clk);
      check_digit("zero_d0", 8'h01, 8'hFC);
      check_digit("zero_d1", 8'h02, 8'h00);
`else
      check_digit("d2_lead0", 8'h04, 8'hFC);
      check_digit("d7_lead0", 8'h80, 8'hFC);
`endif
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mileage_display_scan.md
Name: mileage_display_scan

Overview:
- Parametrised successor to the car dashboard mileage display.
- Converts a binary odometer count to BCD with a sequential double-dabble engine, replacing combinational div/mod.
- Drives a time-multiplexed N-digit seven-segment bank (shared segment bus plus one-hot anode select) and an N-bit flowing LED bar.
- Sits between the odometer record counter and the board display pins; gated by the vehicle power state.

Parameters:
- DIGITS, 8, number of seven-segment digits scanned (1..8)
- BIN_W, 27, width of the binary mileage input
- LED_N, 8, width of the flowing LED bar
- SCAN_DIV, 100000, clk cycles per digit dwell
- FLOW_DIV, 50000000, clk cycles per LED shift step

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- power_now  in  1  1 = vehicle powered; 0 = all outputs dark
- dir  in  1  flow direction: 0 = toward MSB, 1 = toward LSB
- record  in  BIN_W  binary mileage
- led  out  LED_N  flowing LED bar, active-high
- seg_out  out  8  segments {a,b,c,d,e,f,g,dp}, active-high; "0" = 8'b1111_1100
- seg_an  out  DIGITS  one-hot digit enable, bit 0 = least-significant digit
- overflow  out  1  record exceeds 10^DIGITS-1

Behaviour:
- Reset is synchronous, active-high. It is sampled on the clk rising edge and overrides power_now.
- Reset values:
  - led = 0, seg_an = 0, seg_out = 0, overflow = 0
  - internal BCD = 0, scan index = 0, LED pattern = 1 (LSB), converter IDLE, dividers = 0
- Converter FSM, states IDLE / SHIFT / DONE:
  - IDLE: when record != last_sampled, latch record into last_sampled and enter SHIFT.
  - SHIFT: runs exactly BIN_W cycles. Each cycle, add 3 to every nibble >= 5, then shift left one bit.
  - DONE: one cycle. Copy the BCD result to the display register atomically, update overflow, return to IDLE.
  - Latency: BIN_W+2 cycles from a record change to the new digits being visible.
  - record changes during SHIFT are ignored until IDLE, then picked up. No intermediate value is ever shown.
- Overflow: if record > 10^DIGITS-1, overflow = 1 and every digit shows 9 (saturation). Internal BCD holds ceil(BIN_W/3.32) nibbles; only the low DIGITS are displayed.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the scan index increments modulo DIGITS (DIGITS-1 -> 0).
  - seg_an and seg_out are registered and change in the same cycle.
  - seg_out is the encoding of nibble[index]. Nibble values 10..15 are impossible; if they occur, encode as blank (0).
- Flow LED:
  - On each FLOW_DIV wrap, rotate the one-hot pattern: dir = 0 rotates left, dir = 1 rotates right.
  - Wrap-around: MSB -> LSB and LSB -> MSB.
  - A dir change takes effect at the next step.
- Power off (power_now = 0):
  - led, seg_an, seg_out and overflow are forced to 0 on the next cycle.
  - Dividers and scan index hold. The LED pattern reloads to 1.
  - The converter keeps running, so digits are current at power-on.
  - Outputs resume on the cycle after power_now rises, at scan index 0.
- Reset mid-conversion aborts the conversion to IDLE. last_sampled resets to 0, so a nonzero record reconverts immediately after reset.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most-significant nonzero digit output seg_out = 0, with their anode still scanned.
  - Digit 0 always shows, so 0 displays as a single "0".
  - Blanking mask is computed in the DONE state and registered with the digits.
- Undefined: all DIGITS digits show, including leading zeros (e.g. 00000042).

Decomposition:
- Shared package mileage_disp_pkg:
  - SEG_W = 8
  - segment encoding constants SEG_0..SEG_9 and SEG_BLANK
  - a seg_encode function from 4-bit digit to SEG_W bits
  - converter state typedef {IDLE, SHIFT, DONE}
- Sub-module bin2bcd_seq, parametrised by BIN_W. Ports: start, busy, done pulse, bcd out. Scan, flow and power gating stay in the top module.

Test Plan (SCAN_DIV = 4, FLOW_DIV = 8, DIGITS = 8, BIN_W = 27):
- Reset, power_now = 1, record = 12345678 -> after 29 cycles, digit i shows 8,7,6,5,4,3,2,1 for i = 0..7; seg_an cycles 0x01, 0x02 ... 0x80, 0x01 every 4 clocks; overflow = 0.
- record = 99999999 then 100000000 -> first shows all 9s with overflow = 0, second shows all 9s with overflow = 1.
- record changed 5 cycles into a conversion -> first value displayed, then the second value BIN_W+2 cycles after IDLE; no corrupted digit pattern is ever observed.
- dir = 0 from reset -> led 0x01, 0x02 ... 0x80, 0x01 every 8 clocks; switch to dir = 1 -> 0x80 after 0x01.
- power_now low mid-scan -> led = seg_an = seg_out = 0 the next cycle; raised -> seg_an = 0x01 the next cycle, digits correct; rst asserted with power_now = 0 -> reset values.
- LEADING_ZERO_BLANK_EN defined, record = 42 -> digits 2..7 have seg_out = 0, digit 0 = SEG_2, digit 1 = SEG_4; record = 0 -> only digit 0 shows 8'b1111_1100.
